// File: rtl/dm_access_ctrl.sv
// CPU-to-data-memory access controller: latches one load/store, drives registered memory strobes, returns a response pulse.
// `define DM_MISALIGN_SPLIT_EN to split misaligned half/word accesses into byte accesses instead of rejecting them.
module dm_access_ctrl #(
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsign,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              DMRd,
    output logic              DMWr,
    output logic              half,
    output logic              o_byte,   // byte strobe; "byte" is a reserved word
    output logic              unsign,
    output logic [ADDR_W-1:0] Daddr,
    output logic [31:0]       DataIn,
    input  logic [31:0]       DataOut
);

    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

    state_t            r_state;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_unsign;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [1:0]        r_idx;
    logic [31:0]       r_split;

    logic              w_reserved;
    logic              w_misalign;
    logic              w_split_last;
    logic [1:0]        w_idx_next;
    logic [ADDR_W-1:0] w_split_addr;
    logic [7:0]        w_split_wbyte;
    logic [31:0]       w_split_data;
    logic [31:0]       w_split_ext;

    // Request classification and byte-split datapath
    always_comb begin
        w_reserved    = (req_size == 2'b11);
        w_misalign    = ((req_size == 2'b01) && req_addr[0]) ||
                        ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
        w_idx_next    = r_idx + 2'd1;
        w_split_addr  = r_addr + ADDR_W'(w_idx_next);
        w_split_wbyte = 8'(r_wdata >> {w_idx_next, 3'b000});
        w_split_data  = r_split | (32'(DataOut[7:0]) << {r_idx, 3'b000});
        w_split_last  = (r_size == 2'b01) ? (r_idx == 2'd1) : (r_idx == 2'd3);
        if (r_size == 2'b01) begin
            w_split_ext = r_unsign ? {16'h0000, w_split_data[15:0]}
                                   : {{16{w_split_data[15]}}, w_split_data[15:0]};
        end else begin
            w_split_ext = w_split_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            DMRd       <= 1'b0;
            DMWr       <= 1'b0;
            half       <= 1'b0;
            o_byte     <= 1'b0;
            unsign     <= 1'b0;
            Daddr      <= '0;
            DataIn     <= 32'h0;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsign   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            r_idx      <= 2'd0;
            r_split    <= 32'h0;
        end else begin
            // Memory strobes and the response pulse are single-cycle unless re-asserted below
            resp_valid <= 1'b0;
            DMRd       <= 1'b0;
            DMWr       <= 1'b0;
            half       <= 1'b0;
            o_byte     <= 1'b0;
            unsign     <= 1'b0;
            Daddr      <= '0;
            DataIn     <= 32'h0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we      <= req_we;
                        r_size    <= req_size;
                        r_unsign  <= req_unsign;
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_idx     <= 2'd0;
                        r_split   <= 32'h0;
                        req_ready <= 1'b0;
                        if (w_reserved) begin
                            r_state    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else if (w_misalign) begin
`ifdef DM_MISALIGN_SPLIT_EN
                            r_state <= SPLIT;
                            DMRd    <= ~req_we;
                            DMWr    <= req_we;
                            o_byte  <= 1'b1;
                            unsign  <= 1'b1;
                            Daddr   <= req_addr;
                            DataIn  <= {24'h0, req_wdata[7:0]};
`else
                            r_state    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
`endif
                        end else begin
                            r_state <= ACCESS;
                            DMRd    <= ~req_we;
                            DMWr    <= req_we;
                            half    <= (req_size == 2'b01);
                            o_byte  <= (req_size == 2'b00);
                            unsign  <= req_unsign;
                            Daddr   <= req_addr;
                            DataIn  <= req_wdata;
                        end
                    end
                end
                ACCESS: begin
                    r_state    <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= r_we ? 32'h0 : DataOut;
                end
                SPLIT: begin
                    if (w_split_last) begin
                        r_state    <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= r_we ? 32'h0 : w_split_ext;
                    end else begin
                        r_idx   <= w_idx_next;
                        r_split <= w_split_data;
                        DMRd    <= ~r_we;
                        DMWr    <= r_we;
                        o_byte  <= 1'b1;
                        unsign  <= 1'b1;
                        Daddr   <= w_split_addr;
                        DataIn  <= {24'h0, w_split_wbyte};
                    end
                end
                RESP: begin
                    r_state   <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    r_state   <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/dm_access_ctrl.md
DM_ACCESS_CTRL -- requirements
Module: dm_access_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 7, giving the byte-address width of the data memory.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, 1 bit: the CPU presents an access.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block can accept an access.
REQ-006 The block SHALL have port req_we, input, 1 bit: 1 store, 0 load.
REQ-007 The block SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 reserved.
REQ-008 The block SHALL have port req_unsign, input, 1 bit: zero-extend loads (lbu/lhu).
REQ-009 The block SHALL have port req_addr, input, ADDR_W bits: byte address.
REQ-010 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 The block SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port resp_rdata, output, 32 bits: extended load data; 0 for stores and errors.
REQ-013 The block SHALL have port resp_err, output, 1 bit: access rejected; valid with resp_valid.
REQ-014 The block SHALL have ports DMRd, DMWr, half, byte and unsign, output, 1 bit each: data-memory read, write, halfword, byte and zero-extend strobes.
REQ-015 The block SHALL have ports Daddr, output, ADDR_W bits, and DataIn, output, 32 bits: memory address and write data.
REQ-016 The block SHALL have port DataOut, input, 32 bits: combinational read data from memory.

Function
REQ-017 The block SHALL implement states IDLE, ACCESS, SPLIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 In IDLE, req_valid=1 SHALL latch all req_* fields and move to ACCESS, SPLIT or RESP on the next edge.
REQ-019 All memory-side outputs SHALL be registered, change only on rising edges, and be 0 outside ACCESS and SPLIT.
REQ-020 ACCESS SHALL last exactly one cycle with DMRd=~req_we, DMWr=req_we, half=(size==01), byte=(size==00), unsign=req_unsign, Daddr=req_addr and DataIn=req_wdata; the memory commits stores on the falling edge inside that cycle.
REQ-021 At the rising edge ending ACCESS, a load SHALL register DataOut into resp_rdata, and the block SHALL move to RESP.
REQ-022 RESP SHALL last one cycle with resp_valid=1, then return to IDLE; aligned access latency SHALL be 2 cycles from the accept edge to resp_valid.
REQ-023 Misaligned is half with addr[0]=1, or word with addr[1:0]!=0; size 11 SHALL always give RESP with resp_err=1 and no memory strobes.
REQ-024 Back-to-back requests SHALL be accepted every 3 cycles (IDLE, ACCESS, RESP); no request SHALL be dropped or reordered.
REQ-025 Byte address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-026 resp_rdata and resp_err SHALL hold their values until the next RESP.

Reset
REQ-027 On a rising edge with rst=1, the state SHALL become IDLE and every output SHALL become 0, except req_ready, which SHALL become 1.
REQ-028 Reset during ACCESS or SPLIT SHALL abort the access without producing resp_valid; a store byte already committed on the preceding falling edge SHALL remain in memory.

Configuration
REQ-029 Macro DM_MISALIGN_SPLIT_EN SHALL select how misaligned accesses are handled.
REQ-030 Without DM_MISALIGN_SPLIT_EN, a misaligned access SHALL go IDLE to RESP with resp_err=1, resp_rdata=0 and no memory strobes.
REQ-031 With DM_MISALIGN_SPLIT_EN, a misaligned access SHALL enter SPLIT for N cycles (N=2 half, N=4 word).
REQ-032 In SPLIT cycle i, the block SHALL issue a byte access with byte=1, unsign=1 and Daddr=addr+i (wrapping), storing req_wdata[8i+7:8i] or capturing DataOut[7:0] into byte lane i.
REQ-033 After SPLIT, the block SHALL enter RESP with resp_err=0 and extend half loads per req_unsign; latency SHALL be N+1 cycles.

Verification
REQ-034 The bench SHALL check: sw 0xDEADBEEF at 0x10, then lw at 0x10 -> memory bytes EF,BE,AD,DE at 0x10-0x13, resp_rdata=0xDEADBEEF, resp_valid 2 cycles after accept.
REQ-035 The bench SHALL check: sb 0x80 at 0x21, then lb and lbu at 0x21 -> 0xFFFFFF80 and 0x00000080.
REQ-036 The bench SHALL check: lh at 0x03 -> without macro, resp_err=1, rdata=0 and DMRd never asserted; with macro, bytes [0x03],[0x04]=0x34,0x12 give 0x00001234 after 3 cycles.
REQ-037 The bench SHALL check: with the macro, sw 0x11223344 at 0x7E -> bytes 44,33,22,11 at 0x7E,0x7F,0x00,0x01 (wrap).
REQ-038 The bench SHALL check: rst asserted in the ACCESS cycle of an lw -> next cycle state IDLE, req_ready=1, no resp_valid, all memory strobes 0.
